negedge_strobe_tx: RTL

- Transmit-side partner for negedge-captured registers, such as a 7-bit word latched on the falling edge of a derived strobe under an async reset.
- Accepts parallel words over a valid/ready handshake.
- Drives a registered strobe plus a data bus that is stable across the strobe falling edge, so the downstream negedge register always latches a defined value.
- Used in the differential-simulation harness to exercise derived-clock negedge capture deterministically.

---
 rtl/negedge_strobe_tx_pkg.sv | 27 ++
 rtl/negedge_strobe_tx_phase_timer.sv | 30 +++
 rtl/negedge_strobe_tx.sv | 132 +++++++++++++
 3 files changed

// File: rtl/negedge_strobe_tx_pkg.sv
// Shared types and sizing helpers for the negedge strobe transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: tx_state_e FSM encoding, SENT_W words_sent width, cnt_w() timer width helper.
package negedge_strobe_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      HIGH  = 2'd2,
      LOW   = 2'd3
   } tx_state_e;

   localparam int SENT_W = 16;

   // The timer only ever holds (phase length - 1), so it needs enough bits
   // for (max phase length - 1); never less than one bit.
   function automatic int cnt_w(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m <= 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/negedge_strobe_tx_phase_timer.sv
// Loadable down-counter with zero flag, timing every strobe phase.
// Latency: load takes effect on the next clkin edge; zero is decoded from the count.
// Backpressure: none; stops at zero until reloaded.
//
// Ports: clkin, rstn (async active-low), load/load_val (reload), zero (count is 0).
module strobe_phase_timer #(
   parameter int W = 1
) (
   input  logic         clkin,
   input  logic         rstn,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clkin or negedge rstn) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/negedge_strobe_tx.sv
// Strobe transmitter: presents a word, raises strobe, drops it so a negedge receiver latches stable data.
// Latency: strobe rises SETUP_CYC edges after accept, falls HIGH_CYC later, ready returns LOW_CYC after that.
// Backpressure: in_ready low from accept until the hold window ends; offered words wait on in_valid.
//
// Ports: clkin, rstn, in_valid/in_ready/in_data (word input), strobe_out, data_out,
// busy, words_sent (completed falling edges, wraps). With NEGEDGE_STROBE_TX_PARITY_EN
// defined, data_par carries the even parity of the presented word.
module negedge_strobe_tx
   import negedge_strobe_pkg::*;
#(
   parameter int DW        = 7,
   parameter int SETUP_CYC = 1,
   parameter int HIGH_CYC  = 2,
   parameter int LOW_CYC   = 2
) (
   input  logic              clkin,
   input  logic              rstn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DW-1:0]     in_data,
   output logic              strobe_out,
   output logic [DW-1:0]     data_out,
   output logic              busy,
   output logic [SENT_W-1:0] words_sent
`ifdef NEGEDGE_STROBE_TX_PARITY_EN
   ,
   output logic              data_par
`endif
);

   localparam int CNT_W = cnt_w(SETUP_CYC, HIGH_CYC, LOW_CYC);
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] HIGH_LD  = CNT_W'(HIGH_CYC - 1);
   localparam logic [CNT_W-1:0] LOW_LD   = CNT_W'(LOW_CYC - 1);

   tx_state_e          state;
   logic               accept;
   logic               fall;
   logic               ph_zero;
   logic               tmr_load;
   logic [CNT_W-1:0]   tmr_val;
   logic [SENT_W-1:0]  sent_nxt;

   assign accept = (state == IDLE) && in_valid && in_ready;
   assign fall   = (state == HIGH) && ph_zero;

   // Each phase transition reloads the timer with the next phase length.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      if (accept) begin
         tmr_load = 1'b1;
         tmr_val  = SETUP_LD;
      end else if ((state == SETUP) && ph_zero) begin
         tmr_load = 1'b1;
         tmr_val  = HIGH_LD;
      end else if (fall) begin
         tmr_load = 1'b1;
         tmr_val  = LOW_LD;
      end
   end

   strobe_phase_timer #(.W(CNT_W)) u_timer (
      .clkin    (clkin),
      .rstn     (rstn),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (ph_zero)
   );

   // Only the clocked falling edge counts; a reset-induced drop clears the count instead.
   assign sent_nxt = fall ? words_sent + SENT_W'(1) : words_sent;

   always_ff @(posedge clkin or negedge rstn) begin
      if (!rstn) begin
         words_sent <= '0;
      end else begin
         words_sent <= sent_nxt;
      end
   end

   always_ff @(posedge clkin or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         strobe_out <= 1'b0;
         data_out   <= '0;
         in_ready   <= 1'b0;
         busy       <= 1'b0;
`ifdef NEGEDGE_STROBE_TX_PARITY_EN
         data_par   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  // data_out is only ever loaded here, so it is frozen for the whole strobe.
                  data_out <= in_data;
`ifdef NEGEDGE_STROBE_TX_PARITY_EN
                  data_par <= ^in_data;
`endif
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= SETUP;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            SETUP: begin
               if (ph_zero) begin
                  strobe_out <= 1'b1;
                  state      <= HIGH;
               end
            end
            HIGH: begin
               if (ph_zero) begin
                  strobe_out <= 1'b0;
                  state      <= LOW;
               end
            end
            LOW: begin
               if (ph_zero) begin
                  busy     <= 1'b0;
                  in_ready <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
